// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate: operand register, PIPE product stages, then a saturating
// accumulator that emits one dot-product per first/last-delimited packet on a valid/ready port.
module mac_pipe #(
    parameter int unsigned A_W    = 8,
    parameter int unsigned B_W    = 8,
    parameter int unsigned ACC_W  = 24,
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned PIPE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned P_W = A_W + B_W;

    if (ACC_W < P_W) begin : g_bad_acc_w
        $error("mac_pipe: ACC_W must be >= A_W+B_W");
    end
    if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
        $error("mac_pipe: PIPE must be in 1..4");
    end

    logic             stall;
    logic             op_v, op_first, op_last;
    logic [A_W-1:0]   op_a;
    logic [B_W-1:0]   op_b;
    logic [P_W-1:0]   prod;
    logic [PIPE-1:0]  st_v, st_first, st_last;
    logic [P_W-1:0]   st_prod [PIPE];
    logic [ACC_W-1:0] prod_ext, sat, acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic             sum_ovf, ovf_q, ovf_d;
    logic             out_valid_d, out_ovf_d;
    logic [ACC_W-1:0] out_data_d;

    // Any held-but-unaccepted result freezes the whole datapath.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst | ~stall;

    if (SIGNED) begin : g_signed
        logic signed [P_W-1:0] a_ext, b_ext;
        assign a_ext    = P_W'($signed(op_a));
        assign b_ext    = P_W'($signed(op_b));
        assign prod     = a_ext * b_ext;
        assign prod_ext = ACC_W'($signed(st_prod[PIPE-1]));
        assign sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        // True sign of the sum is the extra bit; clamp towards it.
        assign sat      = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_unsigned
        assign prod     = P_W'(op_a) * P_W'(op_b);
        assign prod_ext = ACC_W'(st_prod[PIPE-1]);
        assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
        assign sum_ovf  = sum[ACC_W];
        assign sat      = '1;
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (st_v[PIPE-1]) begin
            if (st_first[PIPE-1]) begin
                acc_d = prod_ext;
                ovf_d = 1'b0;
            end else begin
                acc_d = sum_ovf ? sat : sum[ACC_W-1:0];
                ovf_d = ovf_q | sum_ovf;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid & ~out_ready;
        out_data_d  = out_data;
        out_ovf_d   = out_ovf;
        if (st_v[PIPE-1] && st_last[PIPE-1]) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
            out_ovf_d   = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_v      <= 1'b0;
            op_first  <= 1'b0;
            op_last   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            st_v      <= '0;
            st_first  <= '0;
            st_last   <= '0;
            for (int i = 0; i < PIPE; i++) begin
                st_prod[i] <= '0;
            end
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            op_v <= in_valid;
            if (in_valid) begin
                op_a     <= in_a;
                op_b     <= in_b;
                op_first <= in_first;
                op_last  <= in_last;
            end
            st_v[0]     <= op_v;
            st_first[0] <= op_first;
            st_last[0]  <= op_last;
            st_prod[0]  <= prod;
            for (int i = 1; i < PIPE; i++) begin
                st_v[i]     <= st_v[i-1];
                st_first[i] <= st_first[i-1];
                st_last[i]  <= st_last[i-1];
                st_prod[i]  <= st_prod[i-1];
            end
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_ovf   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: three configurations share one stimulus stream and are checked against
// a beat-level arithmetic model plus directed latency, hold and reset checks.
module tb_mac_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_first, in_last, out_ready;
    logic [7:0]  in_a, in_b;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, f0, f1, f2;
    logic [23:0] d0;
    logic [15:0] d1, d2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] d0;
        logic        o0;
        logic [15:0] d1;
        logic        o1;
        logic [15:0] d2;
        logic        o2;
    } exp_t;

    exp_t   expq[$];
    longint acc_m[3];
    bit     ovf_m[3];

    always #5 clk = ~clk;

    mac_pipe #(.A_W(8), .B_W(8), .ACC_W(24), .SIGNED(1'b1), .PIPE(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
        .out_data(d0), .out_ovf(f0)
    );
    mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(1'b1), .PIPE(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_data(d1), .out_ovf(f1)
    );
    mac_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(1'b0), .PIPE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
        .out_data(d2), .out_ovf(f2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Dot-product arithmetic per configuration: index 0 = s24, 1 = s16, 2 = u16.
    task automatic model_beat(input logic [7:0] a, input logic [7:0] b,
                              input logic first, input logic last);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            bit     sgn;
            int     w;
            longint p, s, hi, lo;
            sgn = (k != 2);
            w   = (k == 0) ? 24 : 16;
            p   = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
            hi  = sgn ? (64'sd1 <<< (w - 1)) - 1 : (64'sd1 <<< w) - 1;
            lo  = sgn ? -(64'sd1 <<< (w - 1)) : 0;
            if (first) begin
                acc_m[k] = p;
                ovf_m[k] = 1'b0;
            end else begin
                s = acc_m[k] + p;
                if (s > hi) begin
                    s = hi;
                    ovf_m[k] = 1'b1;
                end else if (s < lo) begin
                    s = lo;
                    ovf_m[k] = 1'b1;
                end
                acc_m[k] = s;
            end
        end
        if (last) begin
            e.d0 = 24'(acc_m[0]);
            e.o0 = ovf_m[0];
            e.d1 = 16'(acc_m[1]);
            e.o1 = ovf_m[1];
            e.d2 = 16'(acc_m[2]);
            e.o2 = ovf_m[2];
            expq.push_back(e);
        end
    endtask

    // Inputs change just after posedge; the negedge view is what the next edge will act on.
    exp_t got;
    always @(negedge clk) begin
        if (!rst) begin
            expq.delete();
            acc_m = '{0, 0, 0};
            ovf_m = '{0, 0, 0};
        end else begin
            if (ov0 && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_result", {31'b0, ov0}, 32'h0);
                end else begin
                    got = expq.pop_front();
                    chk("s24_data", d0, got.d0);
                    chk("s24_ovf", f0, got.o0);
                    chk("s16_valid", ov1, 1);
                    chk("s16_data", d1, got.d1);
                    chk("s16_ovf", f1, got.o1);
                    chk("u16_valid", ov2, 1);
                    chk("u16_data", d2, got.d2);
                    chk("u16_ovf", f2, got.o2);
                end
            end
            if (in_valid && rdy0) model_beat(in_a, in_b, in_first, in_last);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                             input logic first, input logic last, output int waits);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        waits    = 0;
        while (!rdy0 && waits < 50) begin
            tick(1);
            waits++;
        end
        if (waits >= 50) chk("send_timeout", rdy0, 1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!ov0 && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, ov0, 1);
    endtask

    int w;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tick(2);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", d0, 0);
        chk("rst_out_ovf", f0, 0);
        chk("rst_in_ready", rdy0, 1);
        rst = 1'b1;
        out_ready = 1'b1;
        tick(1);

        // Single-beat latency: valid exactly three edges after the accept edge.
        send_beat(8'hFD, 8'd5, 1'b1, 1'b1, w);
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            chk($sformatf("t1_valid_edge%0d", c), ov0, (c == 3));
        end
        chk("t1_data", d0, 24'hFFFFF1);
        chk("t1_ovf", f0, 0);

        for (int i = 0; i < 4; i++) begin
            send_beat(8'(2 * i + 1), 8'(2 * i + 2), (i == 0), (i == 3), w);
            chk($sformatf("t2_ready_beat%0d", i), w, 0);
        end
        wait_out("t2_timeout");
        chk("t2_data", d0, 100);
        chk("t2_ovf", f0, 0);

        for (int i = 0; i < 3; i++) send_beat(8'd127, 8'd127, (i == 0), (i == 2), w);
        wait_out("t3a_timeout");
        chk("t3a_data", d1, 16'h7FFF);
        chk("t3a_ovf", f1, 1);
        for (int i = 0; i < 3; i++) send_beat(8'h80, 8'd127, (i == 0), (i == 2), w);
        wait_out("t3b_timeout");
        chk("t3b_data", d1, 16'h8000);
        chk("t3b_ovf", f1, 1);
        send_beat(8'd2, 8'd3, 1'b1, 1'b1, w);
        wait_out("t3c_timeout");
        chk("t3c_data", d1, 6);
        chk("t3c_ovf", f1, 0);

        for (int i = 0; i < 2; i++) send_beat(8'd255, 8'd255, (i == 0), (i == 1), w);
        wait_out("t4_timeout");
        chk("t4_data", d2, 16'hFFFF);
        chk("t4_ovf", f2, 1);
        tick(1);

        // Back-pressure: first result parks, pipeline freezes behind it.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send_beat(8'(i), 8'(i), 1'b1, 1'b1, w);
        tick(6);
        chk("t5_hold_valid", ov0, 1);
        chk("t5_hold_data", d0, 1);
        chk("t5_stall_ready", rdy0, 0);
        out_ready = 1'b1;
        chk("t5_res1", d0, 1);
        tick(1);
        chk("t5_res2", d0, 4);
        chk("t5_res2_valid", ov0, 1);
        tick(1);
        chk("t5_res3", d0, 9);
        chk("t5_res3_valid", ov0, 1);
        tick(2);
        chk("t5_no_dup", ov0, 0);

        send_beat(8'd1, 8'd1, 1'b1, 1'b0, w);
        send_beat(8'd2, 8'd2, 1'b0, 1'b0, w);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("t6_rst_valid", ov0, 0);
        chk("t6_rst_data", d0, 0);
        tick(4);
        chk("t6_no_partial", ov0, 0);
        send_beat(8'd2, 8'd2, 1'b1, 1'b1, w);
        wait_out("t6_timeout");
        chk("t6_data", d0, 4);
        tick(1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_first  = ($urandom_range(0, 3) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(15);
        chk("drain_pending", expq.size(), 0);
        chk("drain_valid", ov0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit for the CNN convolution datapath. It is the next generation of the single-cycle 8x8 multiplier. It streams operand pairs through a configurable-depth multiplier pipeline and accumulates products over a packet delimited by first/last flags. It emits one saturated dot-product per packet on a valid/ready output, with back-pressure into the input.

Parameters:
A_W, 8, operand a width.
B_W, 8, operand b width.
ACC_W, 24, accumulator and result width; must be >= A_W+B_W (elaboration error otherwise).
SIGNED, 1, 1 = two's-complement operands, product and accumulator; 0 = unsigned.
PIPE, 2, multiplier register stages, legal range 1..4.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat this cycle
in_a  in  A_W  operand a
in_b  in  B_W  operand b
in_first  in  1  beat starts a new packet; accumulator is reloaded with this product
in_last  in  1  beat ends the packet; result is emitted
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  accumulated, saturated result
out_ovf  out  1  saturation occurred at least once in this packet

Behaviour:
- Reset is synchronous, active-low rst, on clock clk. While rst=0 at a rising edge, all of the following clear: every pipeline valid bit, accumulator, sticky overflow flag, out_valid, out_data (0) and out_ovf (0). Reset mid-packet discards the packet and does not emit a partial result. in_ready is combinational and equals 1 during reset.
- Global stall: stall = out_valid & ~out_ready. in_ready = ~stall. When stall=1, no pipeline register, accumulator or output register changes.
- A beat is accepted on an edge where in_valid & in_ready. Each stage carries a valid bit plus the first/last flags. Bubbles (no accept) advance as invalid stages.
- Multiply: the full product is A_W+B_W bits, signed or unsigned per SIGNED. It is sign-extended (or zero-extended) to ACC_W before accumulation. The product is available PIPE cycles after the accept edge.
- Accumulate stage (one cycle, acts on a valid product):
  - If first=1: acc = product, ovf_flag = 0.
  - Otherwise: acc = sat(acc + product), and ovf_flag |= overflow.
  - A product with first=0 arriving after reset or after a completed packet accumulates onto the current acc (0 after reset). This is not an error.
- Saturation limits: for SIGNED=1 the sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. For SIGNED=0 it clamps to [0, 2^ACC_W-1]. Overflow is detected on the ACC_W+1-bit sum.
- Output: on the same edge that a last=1 product is accumulated:
  - out_data = the new acc value.
  - out_ovf = the new flag value.
  - out_valid = 1.
- Latency, with no stalls: a single-beat packet (first=last=1) accepted at edge 0 gives out_valid=1 after edge PIPE+1.
- Output hold: out_valid, out_data and out_ovf hold stable until out_valid & out_ready. On that edge out_valid drops, unless a new last product completes on the same edge, in which case the new result loads and out_valid stays 1.
- Throughput is one beat per cycle. With out_ready tied high, in_ready stays 1 continuously.
- A beat with first=1 and last=1 forms a one-product packet. Back-to-back packets need no gap cycles.
- in_a, in_b, in_first and in_last are ignored when the beat is not accepted.

Test Plan:
1. Defaults, SIGNED=1. One beat a=8'hFD (-3), b=5, first=last=1, out_ready=1 -> out_valid exactly 3 cycles after accept, out_data=-15 (24'hFFFFF1), out_ovf=0.
2. Four beats (1,2),(3,4),(5,6),(7,8) back-to-back, first on beat 0, last on beat 3 -> single result 100, out_ovf=0. in_ready stays 1 throughout.
3. ACC_W=16, SIGNED=1. Three beats 127*127 -> 32767 with out_ovf=1. Then three beats -128*127 -> -32768 (16'h8000) with out_ovf=1. A following single beat 2*3 -> 6 with out_ovf=0 (flag cleared by first).
4. SIGNED=0, ACC_W=16. Beats 255*255 twice -> 65535, out_ovf=1.
5. Back-pressure: three single-beat packets (1*1, 2*2, 3*3) with out_ready=0 for 6 cycles.
   - out_data holds 1 and in_ready drops while stalled.
   - After out_ready=1, results 1, 4, 9 arrive in order with no loss or duplication.
6. Reset mid-packet: rst=0 for one edge after 2 of 4 beats are accepted -> out_valid=0, out_data=0. A new packet 2*2, first=last=1 -> 4.
